// File: rtl/data_mem_responder.sv
// Word-addressed data memory acting as responder on a load/store request/response bus.
// One transaction in flight, fixed LATENCY wait cycles, registered response held until accepted.
module data_mem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [1:0]  dbg_state_o
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_acc_we;
    logic [31:0]   w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic          w_err;
    logic          w_do_store;
    logic [AW-1:0] w_idx;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds its payload stable from raising valid until that edge.
    assign req_ready_o = (r_state == ST_IDLE) && rst_i;
    assign w_accept    = req_valid_i && req_ready_o;

    // With zero wait states the access happens on the acceptance edge, so bypass the capture regs.
    assign w_acc_we    = (r_state == ST_IDLE) ? req_we_i    : r_we;
    assign w_acc_addr  = (r_state == ST_IDLE) ? req_addr_i  : r_addr;
    assign w_acc_wdata = (r_state == ST_IDLE) ? req_wdata_i : r_wdata;

    assign w_err        = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:2] >= DEPTH_W);
    assign w_idx        = w_acc_addr[AW+1:2];
    assign w_enter_resp = rst_i && (r_state != ST_RESP) && (w_next == ST_RESP);
    assign w_do_store   = w_enter_resp && w_acc_we && !w_err;

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign dbg_state_o = r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (LAT == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we_i;
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_cnt   <= LAT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || w_acc_we) ? 32'd0 : r_mem[w_idx];
            end else if ((r_state == ST_RESP) && rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
                r_rsp_rdata <= 32'd0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    // Storage is deliberately outside reset; w_do_store is already gated by rst_i.
    always_ff @(posedge clk_i) begin
        if (w_do_store) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance a (LATENCY=2) and instance b (LATENCY=0).
// Drivers push expected {err, rdata} and acceptance times; per-instance monitors pop on each response handshake.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [1:0]  a_dbg_state;
  logic        b_rst, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [1:0]  b_dbg_state;

  data_mem_responder #(.DEPTH(128), .LATENCY(2)) u_a (
    .clk_i(clk), .rst_i(a_rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err), .dbg_state_o(a_dbg_state)
  );

  data_mem_responder #(.DEPTH(128), .LATENCY(0)) u_b (
    .clk_i(clk), .rst_i(b_rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err), .dbg_state_o(b_dbg_state)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [32:0] a_exp_q[$];
  logic [32:0] b_exp_q[$];
  logic [63:0] a_acc_q[$];
  logic [63:0] b_acc_q[$];
  logic        a_prev_v = 1'b0;
  logic        b_prev_v = 1'b0;
  logic [63:0] b_last_acc = 64'd0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (a_rsp_valid && !a_prev_v) begin
      chk("a_rsp_expected", 64'(a_exp_q.size() != 0), 64'd1);
      if (a_exp_q.size() != 0) chk("a_latency", 64'($time) - a_acc_q[0], 64'd25);
    end
    if (a_rsp_valid && a_rsp_ready && a_exp_q.size() != 0) begin
      chk("a_rsp", {31'd0, a_rsp_err, a_rsp_rdata}, {31'd0, a_exp_q[0]});
      void'(a_exp_q.pop_front());
      void'(a_acc_q.pop_front());
    end
    a_prev_v = a_rsp_valid;
  end

  always @(negedge clk) begin
    if (b_rsp_valid && !b_prev_v) begin
      chk("b_rsp_expected", 64'(b_exp_q.size() != 0), 64'd1);
      if (b_exp_q.size() != 0) chk("b_latency", 64'($time) - b_acc_q[0], 64'd5);
    end
    if (b_rsp_valid && b_rsp_ready && b_exp_q.size() != 0) begin
      chk("b_rsp", {31'd0, b_rsp_err, b_rsp_rdata}, {31'd0, b_exp_q[0]});
      void'(b_exp_q.pop_front());
      void'(b_acc_q.pop_front());
    end
    b_prev_v = b_rsp_valid;
  end

  // ---------------- drivers ----------------
  task automatic a_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rd, input bit push);
    int waited = 0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    while (!a_req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("a_accept_in_time", 64'(waited < 50), 64'd1);
    if (push) begin
      a_exp_q.push_back({exp_err, exp_rd});
      a_acc_q.push_back(64'($time) + 64'd5);
    end
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance: the captured request must be the one used.
    a_req_valid = 1'b0; a_req_we = 1'($urandom_range(0, 1));
    a_req_addr = 32'hFFFF_FFFC; a_req_wdata = $urandom;
  endtask

  task automatic a_wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_req_ready && n < 50);
    chk("a_idle_in_time", 64'(n < 50), 64'd1);
  endtask

  task automatic b_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rd, input bit check_spacing);
    int waited = 0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
    while (!b_req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("b_accept_in_time", 64'(waited < 50), 64'd1);
    b_exp_q.push_back({exp_err, exp_rd});
    b_acc_q.push_back(64'($time) + 64'd5);
    @(posedge clk);
    if (check_spacing) chk("b_accept_spacing", 64'($time) - b_last_acc, 64'd20);
    b_last_acc = 64'($time);
    #1;
    b_req_valid = 1'b0; b_req_we = 1'($urandom_range(0, 1));
    b_req_addr = 32'hFFFF_FFFC; b_req_wdata = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    a_rst = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'd0; a_req_wdata = 32'd0;
    a_rsp_ready = 1'b1;
    b_rst = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0;
    b_rsp_ready = 1'b1;

    // 1. reset held for two edges
    repeat (2) @(negedge clk);
    chk("a_ready_in_reset", 64'(a_req_ready), 64'd0);
    a_rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);
    chk("a_reset_ready", 64'(a_req_ready), 64'd1);
    chk("a_reset_valid", 64'(a_rsp_valid), 64'd0);
    chk("a_reset_rdata", 64'(a_rsp_rdata), 64'd0);
    chk("a_reset_err", 64'(a_rsp_err), 64'd0);
    chk("a_reset_state", 64'(a_dbg_state), 64'd0);
    chk("b_reset_ready", 64'(b_req_ready), 64'd1);

    // 2. store then load, plus the top word of the array
    a_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);         a_wait_idle();
    a_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);         a_wait_idle();
    a_req(1'b1, 32'h1FC, 32'h0BADF00D, 1'b0, 32'h0, 1'b1);        a_wait_idle();
    a_req(1'b0, 32'h1FC, 32'h0, 1'b0, 32'h0BADF00D, 1'b1);        a_wait_idle();

    // 3. backpressure: response held for 5 cycles with no new request accepted
    a_rsp_ready = 1'b0;
    a_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    n = 0;
    while (!a_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a_bp_valid_in_time", 64'(n < 20), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("a_bp_valid", 64'(a_rsp_valid), 64'd1);
      chk("a_bp_rdata", 64'(a_rsp_rdata), 64'hDEADBEEF);
      chk("a_bp_err", 64'(a_rsp_err), 64'd0);
      chk("a_bp_req_ready", 64'(a_req_ready), 64'd0);
    end
    @(posedge clk);
    #1 a_rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("a_post_hs_valid", 64'(a_rsp_valid), 64'd0);
    chk("a_post_hs_rdata", 64'(a_rsp_rdata), 64'd0);
    chk("a_post_hs_err", 64'(a_rsp_err), 64'd0);
    chk("a_post_hs_ready", 64'(a_req_ready), 64'd1);

    // 4. errors: misaligned store must not write, out-of-range load
    a_req(1'b1, 32'h13, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);         a_wait_idle();
    a_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);         a_wait_idle();
    a_req(1'b0, 32'h200, 32'h0, 1'b1, 32'h0, 1'b1);               a_wait_idle();
    a_req(1'b1, 32'h200, 32'h11111111, 1'b1, 32'h0, 1'b1);        a_wait_idle();

    // 5. reset during WAIT abandons an in-flight store
    a_req(1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0, 1'b1);         a_wait_idle();
    a_req(1'b1, 32'h20, 32'h55AA55AA, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("a_in_wait", 64'(a_dbg_state), 64'd1);
    a_rst = 1'b0;
    @(negedge clk);
    chk("a_abort_valid", 64'(a_rsp_valid), 64'd0);
    a_rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("a_abort_idle_valid", 64'(a_rsp_valid), 64'd0);
    a_req(1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678, 1'b1);         a_wait_idle();

    // 6. zero-latency instance, requests back to back every 2 cycles
    b_req(1'b1, 32'h8, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    b_req(1'b0, 32'h8, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1);
    b_req(1'b1, 32'hC, 32'h00000001, 1'b0, 32'h0, 1'b1);
    b_req(1'b0, 32'hC, 32'h0, 1'b0, 32'h00000001, 1'b1);
    b_req(1'b0, 32'h1, 32'h0, 1'b1, 32'h0, 1'b1);
    b_req(1'b0, 32'h8, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1);

    repeat (5) @(negedge clk);
    chk("a_all_responses", 64'(a_exp_q.size()), 64'd0);
    chk("b_all_responses", 64'(b_exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
